pwm_peripheral: RTL and testbench

//  Downstream consumer of the SPI register file. Drives 16 output pins from the five
//  8-bit control registers: a per-pin output enable, a per-pin PWM-mode select and a

---
 rtl/spi_pwm_pkg.sv | 31 +++
 rtl/pwm_timebase.sv | 43 ++++
 rtl/pwm_peripheral.sv | 64 ++++++
 tb/tb_pwm_peripheral.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pwm_pkg.sv
// Constants shared by the SPI register file and the PWM peripheral:
// register map, PWM width and the pin-mode decode helper.
package spi_pwm_pkg;

  localparam logic [6:0] ADDR_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_DUTY     = 7'h04;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] FULL_ON_DUTY = 8'hFF;

  typedef enum logic [1:0] {
    PIN_OFF,
    PIN_HIGH,
    PIN_PWM
  } pin_mode_e;

  // Output enable dominates; the PWM select only matters for enabled pins.
  function automatic logic pin_level(input logic en_out, input logic en_pwm, input logic lvl);
    pin_mode_e mode;
    mode = !en_out ? PIN_OFF : (en_pwm ? PIN_PWM : PIN_HIGH);
    case (mode)
      PIN_PWM:  return lvl;
      PIN_HIGH: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit free-running PWM counter; flags the last step of
// every 256-step period so the top level can reload its duty shadow.
module pwm_timebase
  import spi_pwm_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PWM_W-1:0] pwm_cnt_o,
  output logic             tick_o,
  output logic             boundary_o
);

  // Keep at least one bit so PRESCALE=1 still elaborates (counter sits at 0).
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               tick;

  always_comb begin
    tick        = (presc_cnt_q == PRESC_MAX);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign pwm_cnt_o  = pwm_cnt_q;
  assign tick_o     = tick;
  assign boundary_o = tick && (pwm_cnt_q == {PWM_W{1'b1}});

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: per-pin enable / PWM select with one shared,
// period-shadowed duty cycle. Every output is driven straight from a flop.
module pwm_peripheral #(
  parameter int                          PRESCALE     = 10,
  parameter logic [spi_pwm_pkg::PWM_W-1:0] FULL_ON_DUTY = spi_pwm_pkg::FULL_ON_DUTY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);
  import spi_pwm_pkg::*;

  logic [15:0]      en_out, en_pwm;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [15:0]      pwm_out_q, pwm_out_d;
  logic             period_start_q;
  logic             tick, boundary, pwm_lvl;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt_o (pwm_cnt),
    .tick_o    (tick),
    .boundary_o(boundary)
  );

  // Duty is only sampled on the period boundary so a running period is never disturbed.
  always_comb begin
    duty_shadow_d = (tick && boundary) ? pwm_duty_cycle : duty_shadow_q;
    pwm_lvl       = (duty_shadow_q == FULL_ON_DUTY) || (pwm_cnt < duty_shadow_q);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pin
    assign pwm_out_d[gi] = pin_level(en_out[gi], en_pwm[gi], pwm_lvl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q  <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= boundary;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: a cycle-level timeline model runs
// alongside directed vectors, waveform measurements and random stimulus.
module tb_pwm_peripheral;
  localparam int P      = 10;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] pwm_out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P), .FULL_ON_DUTY(8'hFF)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .pwm_out        (pwm_out),
    .period_start   (period_start)
  );

  typedef struct packed {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference model: position in the period is derived from cycles since reset.
  task automatic monitor();
    int unsigned t = 0;
    int unsigned phase;
    int unsigned cnt;
    logic [7:0]  shadow = '0;
    logic [15:0] exp_out;
    logic        exp_ps;
    logic        lvl;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; shadow = '0; exp_out = '0; exp_ps = 1'b0;
      end else begin
        phase = t % PERIOD;
        cnt   = phase / P;
        lvl   = (shadow == 8'hFF) || (cnt < shadow);
        for (int i = 0; i < 16; i++)
          exp_out[i] = en_out[i] && (!en_pwm[i] || lvl);
        exp_ps = (phase == PERIOD - 1);
        if (exp_ps) shadow = duty;
        t++;
      end
      @(negedge clk);
      checks++;
      if (pwm_out !== exp_out || period_start !== exp_ps) begin
        errors++;
        $display("FAIL model t=%0d: pwm_out=%h period_start=%b expected pwm_out=%h period_start=%b",
                 t, pwm_out, period_start, exp_out, exp_ps);
      end
    end
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!period_start && n <= PERIOD + 100);
    chk("period_start_seen", int'(period_start), 1);
  endtask

  // Counts pwm_out[0] high cycles over one full period; optionally rewrites duty mid-period.
  task automatic measure(input bit do_wait, input int change_at, input logic [7:0] change_val,
                         output int high, output int first);
    int n;
    if (do_wait) wait_ps(n);
    high  = 0;
    first = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(posedge clk); #1;
      if (k == change_at) duty = change_val;
      if (k == 1) first = int'(pwm_out[0]);
      if (pwm_out[0]) high++;
    end
  endtask

  initial begin
    int n, high, first;
    fork
      monitor();
    join_none

    // Reset held for 3 clocks, then time to first period_start.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_period_start", int'(period_start), 0);
    rst = 1'b0;
    wait_ps(n);
    chk("first_ps_latency", n, PERIOD);

    // Static pin mux; duty_shadow is 0 so PWM-selected pins read low.
    vecs[0] = '{eo: 16'hFFFF, ep: 16'h0000, exp: 16'hFFFF};
    vecs[1] = '{eo: 16'h00F0, ep: 16'h0000, exp: 16'h00F0};
    vecs[2] = '{eo: 16'hFFFF, ep: 16'hFFFF, exp: 16'h0000};
    vecs[3] = '{eo: 16'hA5A5, ep: 16'h0F0F, exp: 16'hA0A0};
    vecs[4] = '{eo: 16'h0000, ep: 16'hFFFF, exp: 16'h0000};
    vecs[5] = '{eo: 16'h1234, ep: 16'h0034, exp: 16'h1200};
    for (int v = 0; v < 6; v++) begin
      en_out = vecs[v].eo;
      en_pwm = vecs[v].ep;
      @(posedge clk); #1;
      chk($sformatf("mux_vec%0d", v), int'(pwm_out), int'(vecs[v].exp));
    end

    // 50% duty, then preload duty 0 late in the period (must not affect it).
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    measure(1, PERIOD - 5, 8'h00, high, first);
    chk("duty80_high", high, 1280);
    chk("duty80_rise_after_ps", first, 1);

    for (int r = 0; r < 3; r++) begin
      measure(0, (r == 2) ? PERIOD - 5 : -1, 8'hFF, high, first);
      chk($sformatf("duty00_high_p%0d", r), high, 0);
    end
    for (int r = 0; r < 3; r++) begin
      measure(0, (r == 2) ? PERIOD - 5 : -1, 8'h01, high, first);
      chk($sformatf("dutyFF_high_p%0d", r), high, PERIOD);
    end
    measure(0, PERIOD - 5, 8'h40, high, first);
    chk("duty01_high", high, 10);
    chk("duty01_rise_after_ps", first, 1);

    // Mid-period duty change at pwm_cnt=0x20.
    measure(0, 320, 8'hC0, high, first);
    chk("duty40_midchange_high", high, 640);
    measure(0, PERIOD - 5, 8'h80, high, first);
    chk("dutyC0_next_high", high, 1920);

    // Reset mid-period at pwm_cnt=0x50 with duty 0x80 active.
    repeat (800) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_pin_high", int'(pwm_out[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pwm_out", int'(pwm_out), 0);
    chk("midrst_period_start", int'(period_start), 0);
    rst = 1'b0;
    measure(0, -1, 8'h00, high, first);
    chk("post_rst_first_high", high, 0);
    chk("post_rst_ps", int'(period_start), 1);
    measure(0, -1, 8'h00, high, first);
    chk("post_rst_second_high", high, 1280);

    // Random traffic against the model, including edge duties and rare resets.
    for (int c = 0; c < 4 * PERIOD; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 3999) == 0);
      if ($urandom_range(0, 49) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 4))
          0:       duty = 8'h00;
          1:       duty = 8'hFF;
          2:       duty = 8'h01;
          3:       duty = 8'hFE;
          default: duty = 8'($urandom);
        endcase
      end
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
